// File: rtl/uart_word_scheduler.sv
// Round-robin scheduler that shares one uart_tx byte transmitter between
// several word producers, sending an optional source tag ahead of each word.
//
// state    | meaning
// IDLE     | no word in flight; arbitrate among valid requesters
// SEND     | wait for tx_ready, then load the current byte and pulse tx_start
// WAIT_ACK | wait for tx_ready to drop (byte taken), then advance or finish
module uart_word_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int WORD_W   = 32,
  parameter int SEND_TAG = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_start,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [3:0]                grant_id
);

  localparam bit        TAG_EN    = (SEND_TAG != 0);
  localparam int        NBYTES    = WORD_W / 8 + (TAG_EN ? 1 : 0);
  localparam logic [7:0] LAST_BYTE = 8'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [3:0]           rr_ptr, rr_ptr_nxt;
  logic [7:0]           byte_cnt, byte_cnt_nxt;
  logic [WORD_W-1:0]    shift_reg, shift_nxt;
  logic [NUM_REQ-1:0]   req_ready_nxt;
  logic [7:0]           tx_data_nxt;
  logic                 tx_start_nxt;
  logic [3:0]           grant_nxt;

  logic [15:0]          valid_pad;
  logic [15:0]          grant_onehot;
  logic [4:0]           cand;
  logic                 arb_found;
  logic [3:0]           arb_idx;
  logic [WORD_W-1:0]    arb_word;
  logic                 tag_slot;
  logic [7:0]           cur_byte;

  assign valid_pad    = 16'(req_valid);
  assign grant_onehot = 16'd1 << arb_idx;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + 5'(i);
      if (cand >= 5'(NUM_REQ)) cand = cand - 5'(NUM_REQ);
      if (!arb_found && valid_pad[cand[3:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[3:0];
      end
    end
  end

  always_comb begin
    arb_word = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_idx == 4'(j)) arb_word = req_data[j*WORD_W +: WORD_W];
    end
  end

  // Data bytes always come from the bottom of shift_reg; it shifts after each one.
  assign tag_slot = TAG_EN && (byte_cnt == 8'd0);
  assign cur_byte = tag_slot ? {4'hA, grant_id} : shift_reg[7:0];

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    byte_cnt_nxt  = byte_cnt;
    shift_nxt     = shift_reg;
    req_ready_nxt = '0;
    tx_data_nxt   = tx_data;
    tx_start_nxt  = 1'b0;
    grant_nxt     = grant_id;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_nxt     = arb_idx;
          shift_nxt     = arb_word;
          req_ready_nxt = grant_onehot[NUM_REQ-1:0];
          rr_ptr_nxt    = (arb_idx == 4'(NUM_REQ - 1)) ? 4'd0 : arb_idx + 4'd1;
          byte_cnt_nxt  = 8'd0;
          state_nxt     = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_data_nxt  = cur_byte;
          tx_start_nxt = 1'b1;
          if (!tag_slot) shift_nxt = shift_reg >> 8;
          state_nxt    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!tx_ready) begin
          if (byte_cnt == LAST_BYTE) begin
            state_nxt = IDLE;
          end else begin
            byte_cnt_nxt = byte_cnt + 8'd1;
            state_nxt    = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
      req_ready <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      byte_cnt  <= byte_cnt_nxt;
      shift_reg <= shift_nxt;
      req_ready <= req_ready_nxt;
      tx_data   <= tx_data_nxt;
      tx_start  <= tx_start_nxt;
      busy      <= (state_nxt != IDLE);
      grant_id  <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_uart_word_scheduler.sv
// Scoreboard bench for uart_word_scheduler: a tagged two-requester instance and
// an untagged instance, each driving a behavioural uart_tx ready/busy model.
module tb_uart_word_scheduler;

  logic clk;
  logic rst;

  // tagged instance
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic        busy;
  logic [3:0]  grant_id;

  // untagged instance
  logic [1:0]  nt_req_valid;
  logic [63:0] nt_req_data;
  logic [1:0]  nt_req_ready;
  logic [7:0]  nt_tx_data;
  logic        nt_tx_start;
  logic        nt_tx_ready;
  logic        nt_busy;
  logic [3:0]  nt_grant_id;

  int n_checks = 0;
  int n_errors = 0;

  // requesters stay valid while served < quota; data reads 0 once they drop
  int          quota  [2];
  int          served [2];
  logic [31:0] word   [2];
  int          nt_quota;
  int          nt_served;
  logic [31:0] nt_word;

  logic [7:0] exp_bytes[$];
  logic [3:0] exp_grants[$];
  logic [7:0] nt_exp_bytes[$];

  int busy_len    = 3;
  int nt_busy_len = 10;
  bit hold;
  int cnt;
  int nt_cnt;
  int n_starts;
  int nt_starts;
  int nt_grants;

  assign req_valid = {served[1] < quota[1], served[0] < quota[0]};
  assign req_data  = {req_valid[1] ? word[1] : 32'h0, req_valid[0] ? word[0] : 32'h0};
  assign nt_req_valid = {1'b0, nt_served < nt_quota};
  assign nt_req_data  = {32'h0, nt_req_valid[0] ? nt_word : 32'h0};

  uart_word_scheduler #(.NUM_REQ(2), .WORD_W(32), .SEND_TAG(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .busy(busy), .grant_id(grant_id)
  );

  uart_word_scheduler #(.NUM_REQ(2), .WORD_W(32), .SEND_TAG(0)) dut_nt (
    .clk(clk), .rst(rst),
    .req_valid(nt_req_valid), .req_data(nt_req_data), .req_ready(nt_req_ready),
    .tx_data(nt_tx_data), .tx_start(nt_tx_start), .tx_ready(nt_tx_ready),
    .busy(nt_busy), .grant_id(nt_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // grant monitor, byte scoreboard and uart_tx model for the tagged instance
  always @(negedge clk) begin
    if (rst) begin
      tx_ready = 1'b1;
      cnt      = 0;
    end else begin
      if (req_ready != 2'b00) begin
        chk("grant_expected", 32'(exp_grants.size() != 0), 1);
        if (exp_grants.size() != 0) begin
          logic [3:0] g;
          g = exp_grants.pop_front();
          chk("grant_onehot", 32'(req_ready), 32'(1) << g);
          chk("grant_id", 32'(grant_id), 32'(g));
        end
        for (int i = 0; i < 2; i++) if (req_ready[i]) served[i]++;
      end
      if (tx_start) begin
        n_starts++;
        chk("start_while_ready", 32'(tx_ready), 1);
        chk("byte_expected", 32'(exp_bytes.size() != 0), 1);
        if (exp_bytes.size() != 0) chk("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
        tx_ready = 1'b0;
        cnt      = busy_len;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (hold) tx_ready = 1'b0;
      else if (!tx_start && cnt == 0) tx_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      nt_tx_ready = 1'b1;
      nt_cnt      = 0;
    end else begin
      if (nt_req_ready != 2'b00) begin
        nt_grants++;
        chk("nt_grant", 32'(nt_req_ready), 32'h1);
        nt_served++;
      end
      if (nt_tx_start) begin
        nt_starts++;
        chk("nt_start_while_ready", 32'(nt_tx_ready), 1);
        chk("nt_byte_expected", 32'(nt_exp_bytes.size() != 0), 1);
        if (nt_exp_bytes.size() != 0) chk("nt_tx_byte", 32'(nt_tx_data), 32'(nt_exp_bytes.pop_front()));
        nt_tx_ready = 1'b0;
        nt_cnt      = nt_busy_len;
      end else if (nt_cnt > 0) begin
        nt_cnt--;
      end
      if (!nt_tx_start && nt_cnt == 0) nt_tx_ready = 1'b1;
    end
  end

  task automatic push_word(input logic [3:0] g, input logic [31:0] w);
    exp_grants.push_back(g);
    exp_bytes.push_back({4'hA, g});
    for (int k = 0; k < 4; k++) exp_bytes.push_back(w[k*8 +: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_bytes.delete();
    exp_grants.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (k < budget && (exp_bytes.size() != 0 || exp_grants.size() != 0 ||
                              busy || req_valid != 2'b00));
    chk(tag, 32'(k < budget), 1);
  endtask

  initial begin
    int s0;
    int k;
    rst = 1'b1;
    hold = 1'b0;
    quota = '{0, 0};
    served = '{0, 0};
    word = '{32'h0, 32'h0};
    nt_quota = 0;
    nt_served = 0;
    nt_word = 32'h0;
    n_starts = 0;
    nt_starts = 0;
    nt_grants = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // single word with tag
    s0 = n_starts;
    word[0] = 32'h0BADBEEF;
    push_word(4'd0, word[0]);
    quota[0]++;
    wait_idle("t1_idle", 500);
    chk("t1_start_count", 32'(n_starts - s0), 5);
    chk("t1_busy_low", 32'(busy), 0);

    // both valid continuously: grants alternate from 0
    do_reset();
    word[0] = 32'h11111111;
    word[1] = 32'h22222222;
    push_word(4'd0, word[0]);
    push_word(4'd1, word[1]);
    push_word(4'd0, word[0]);
    push_word(4'd1, word[1]);
    quota[0] += 2;
    quota[1] += 2;
    wait_idle("t2_idle", 2000);

    // reset during byte 2 of 5, then rr_ptr must be back at 0
    do_reset();
    s0 = n_starts;
    word[0] = 32'hCAFEF00D;
    push_word(4'd0, word[0]);
    quota[0]++;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (k < 500 && n_starts < s0 + 2);
    chk("t4_reach_byte2", 32'(k < 500), 1);
    rst = 1'b1;
    exp_bytes.delete();
    exp_grants.delete();
    @(negedge clk);
    #1;
    chk("t4_req_ready", 32'(req_ready), 0);
    chk("t4_tx_start", 32'(tx_start), 0);
    chk("t4_tx_data", 32'(tx_data), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_grant_id", 32'(grant_id), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    word[0] = 32'h13572468;
    word[1] = 32'h24681357;
    push_word(4'd0, word[0]);
    push_word(4'd1, word[1]);
    quota[0]++;
    quota[1]++;
    wait_idle("t4_idle", 1000);

    // tx_ready held low after the accept
    hold = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    #1;
    word[1] = 32'h89ABCDEF;
    push_word(4'd1, word[1]);
    quota[1]++;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (k < 50 && exp_grants.size() != 0);
    chk("t5_grant_seen", 32'(k < 50), 1);
    s0 = n_starts;
    repeat (1000) @(negedge clk);
    #1;
    chk("t5_no_start", 32'(n_starts - s0), 0);
    chk("t5_busy", 32'(busy), 1);
    hold = 1'b0;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    chk("t5_start_after_ready", 32'(n_starts - s0), 1);
    wait_idle("t5_idle", 500);

    // data changes after accept must not reach the wire
    do_reset();
    word[0] = 32'hDEADBEEF;
    push_word(4'd0, word[0]);
    quota[0]++;
    wait_idle("t6_idle", 500);

    // untagged instance with a slow uart_tx
    s0 = nt_starts;
    nt_word = 32'h0BADBEEF;
    for (int b = 0; b < 4; b++) nt_exp_bytes.push_back(nt_word[b*8 +: 8]);
    nt_quota++;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (k < 1000 && (nt_exp_bytes.size() != 0 || nt_busy || nt_req_valid != 2'b00));
    chk("t3_idle", 32'(k < 1000), 1);
    chk("t3_start_count", 32'(nt_starts - s0), 4);
    chk("t3_grant_count", 32'(nt_grants), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
